// File: rtl/wf_stream_loader.sv
// AXI-Stream loader: latches a waveform parameter word, handshakes init with waveform_stream,
// then captures N DDS I/Q samples through a small skid FIFO and streams them out with tlast.
module wf_stream_loader #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic         clk_in1,
  input  logic         aresetn,
  input  logic         start,
  input  logic [127:0] cfg_parameters,
  input  logic [15:0]  src_i,
  input  logic [15:0]  src_q,
  input  logic         src_valid,
  output logic [127:0] waveform_parameters,
  output logic         init_wf_write,
  input  logic         wf_write_ready,
  output logic [31:0]  wfin_axis_tdata,
  output logic         wfin_axis_tvalid,
  output logic         wfin_axis_tlast,
  output logic [3:0]   wfin_axis_tkeep,
  input  logic         wfin_axis_tready,
  output logic         busy,
  output logic         done,
  output logic         overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StInit   = 2'd1;
  localparam logic [1:0] StStream = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [127:0]         params_q, params_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] cap_cnt_q, cap_cnt_d;
  logic [LEN_WIDTH-1:0] out_cnt_q, out_cnt_d;
  logic [LEN_WIDTH-1:0] len_m1;
  logic                 overflow_q, overflow_d;
  logic                 done_q, done_d;

  logic [31:0]          mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW:0]          count_q, count_d;

  logic fifo_empty, fifo_full;
  logic want_push, push, pop, last_beat;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign len_m1     = len_q - LEN_WIDTH'(1);

  // A pop in the same cycle frees a slot, so a full FIFO can still accept the push.
  assign pop       = !fifo_empty && wfin_axis_tready;
  assign want_push = (state_q == StStream) && src_valid && (cap_cnt_q < len_q);
  assign push      = want_push && (!fifo_full || pop);
  assign last_beat = pop && (out_cnt_q == len_m1);

  always_comb begin
    state_d    = state_q;
    params_d   = params_q;
    len_d      = len_q;
    cap_cnt_d  = cap_cnt_q;
    out_cnt_d  = out_cnt_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          params_d   = cfg_parameters;
          len_d      = cfg_parameters[LEN_WIDTH-1:0];
          overflow_d = 1'b0;
          cap_cnt_d  = '0;
          out_cnt_d  = '0;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          count_d    = '0;
          if (cfg_parameters[LEN_WIDTH-1:0] == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = StInit;
          end
        end
      end
      StInit: begin
        if (wf_write_ready) begin
          state_d = StStream;
        end
      end
      StStream: begin
        if (want_push && !push) begin
          overflow_d = 1'b1;
        end
        if (push) begin
          cap_cnt_d = cap_cnt_q + LEN_WIDTH'(1);
          wr_ptr_d  = wr_ptr_q + AW'(1);
        end
        if (pop) begin
          out_cnt_d = out_cnt_q + LEN_WIDTH'(1);
          rd_ptr_d  = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
          2'b10:   count_d = count_q + (AW+1)'(1);
          2'b01:   count_d = count_q - (AW+1)'(1);
          default: count_d = count_q;
        endcase
        if (last_beat) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in1 or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= StIdle;
      params_q   <= '0;
      len_q      <= '0;
      cap_cnt_q  <= '0;
      out_cnt_q  <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      params_q   <= params_d;
      len_q      <= len_d;
      cap_cnt_q  <= cap_cnt_d;
      out_cnt_q  <= out_cnt_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk_in1) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {src_q, src_i};
    end
  end

  assign wfin_axis_tvalid    = !fifo_empty;
  assign wfin_axis_tdata     = fifo_empty ? 32'h0 : mem_q[rd_ptr_q];
  assign wfin_axis_tkeep     = fifo_empty ? 4'h0 : 4'hF;
  assign wfin_axis_tlast     = !fifo_empty && (out_cnt_q == len_m1);
  assign init_wf_write       = (state_q == StInit);
  assign busy                = (state_q != StIdle);
  assign done                = done_q;
  assign overflow            = overflow_q;
  assign waveform_parameters = params_q;

endmodule

// File: tb/tb_wf_stream_loader.sv
// Randomized bench for wf_stream_loader against a queue-based reference model.
module tb_wf_stream_loader;

  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned LEN_WIDTH  = 16;

  logic         clk = 1'b0;
  logic         aresetn;
  logic         start;
  logic [127:0] cfg_parameters;
  logic [15:0]  src_i, src_q;
  logic         src_valid;
  logic [127:0] waveform_parameters;
  logic         init_wf_write;
  logic         wf_write_ready;
  logic [31:0]  wfin_axis_tdata;
  logic         wfin_axis_tvalid;
  logic         wfin_axis_tlast;
  logic [3:0]   wfin_axis_tkeep;
  logic         wfin_axis_tready;
  logic         busy, done, overflow;

  wf_stream_loader #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .LEN_WIDTH (LEN_WIDTH)
  ) dut (
    .clk_in1            (clk),
    .aresetn            (aresetn),
    .start              (start),
    .cfg_parameters     (cfg_parameters),
    .src_i              (src_i),
    .src_q              (src_q),
    .src_valid          (src_valid),
    .waveform_parameters(waveform_parameters),
    .init_wf_write      (init_wf_write),
    .wf_write_ready     (wf_write_ready),
    .wfin_axis_tdata    (wfin_axis_tdata),
    .wfin_axis_tvalid   (wfin_axis_tvalid),
    .wfin_axis_tlast    (wfin_axis_tlast),
    .wfin_axis_tkeep    (wfin_axis_tkeep),
    .wfin_axis_tready   (wfin_axis_tready),
    .busy               (busy),
    .done               (done),
    .overflow           (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 init handshake, 2 streaming.
  int           m_phase;
  logic [127:0] m_params;
  int unsigned  m_n, m_cap, m_out;
  bit           m_ovf, m_done, m_pop, m_new_done;
  logic [31:0]  m_q[$];

  int beats_total = 0, tlast_total = 0, last_at = 0, init_total = 0, done_total = 0;

  initial begin
    m_phase = 0; m_params = '0; m_n = 0; m_cap = 0; m_out = 0; m_ovf = 0; m_done = 0;
    forever begin
      @(negedge clk);
      if (!aresetn) begin
        m_phase = 0; m_params = '0; m_n = 0; m_cap = 0; m_out = 0; m_ovf = 0; m_done = 0;
        m_q.delete();
      end
      check("busy", busy, m_phase != 0);
      check("init", init_wf_write, m_phase == 1);
      check("done", done, m_done);
      check("overflow", overflow, m_ovf);
      check("params", waveform_parameters, m_params);
      check("tvalid", wfin_axis_tvalid, m_q.size() > 0);
      check("tkeep", wfin_axis_tkeep, (m_q.size() > 0) ? 4'hF : 4'h0);
      check("tlast", wfin_axis_tlast, (m_q.size() > 0) && (m_out == m_n - 1));
      if (m_q.size() > 0) check("tdata", wfin_axis_tdata, m_q[0]);

      if (aresetn) begin
        if (init_wf_write) init_total++;
        if (done) done_total++;
        if (wfin_axis_tvalid && wfin_axis_tready) begin
          beats_total++;
          if (wfin_axis_tlast) begin
            tlast_total++;
            last_at = beats_total;
          end
        end

        m_new_done = 0;
        case (m_phase)
          0: if (start) begin
            m_params = cfg_parameters;
            m_n      = 32'(cfg_parameters[LEN_WIDTH-1:0]);
            m_ovf    = 0;
            m_cap    = 0;
            m_out    = 0;
            if (m_n == 0) m_new_done = 1;
            else m_phase = 1;
          end
          1: if (wf_write_ready) m_phase = 2;
          default: begin
            m_pop = (m_q.size() > 0) && wfin_axis_tready;
            if (m_pop) begin
              void'(m_q.pop_front());
              m_out++;
              if (m_out == m_n) begin
                m_phase    = 0;
                m_new_done = 1;
              end
            end
            if (src_valid && m_cap < m_n) begin
              if (m_q.size() < FIFO_DEPTH) begin
                m_q.push_back({src_q, src_i});
                m_cap++;
              end else begin
                m_ovf = 1;
              end
            end
          end
        endcase
        m_done = m_new_done;
      end
    end
  end

  int valid_pct = 100;
  int ready_pct = 100;
  int b_beats, b_tlast, b_init, b_done;

  task automatic cycle();
    @(posedge clk);
    #1;
    start            = 1'b0;
    wf_write_ready   = 1'b0;
    src_i            = 16'($urandom);
    src_q            = 16'($urandom);
    src_valid        = ($urandom_range(99) < valid_pct);
    wfin_axis_tready = ($urandom_range(99) < ready_pct);
  endtask

  task automatic snap();
    b_beats = beats_total;
    b_tlast = tlast_total;
    b_init  = init_total;
    b_done  = done_total;
  endtask

  task automatic kick(input logic [127:0] cfg);
    start          = 1'b1;
    cfg_parameters = cfg;
    cycle();
  endtask

  task automatic do_init(input int delay);
    check("init_rise", init_wf_write, 1'b1);
    repeat (delay) cycle();
    wf_write_ready = 1'b1;
    cycle();
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_total == b_done && n < budget) begin
      cycle();
      n++;
    end
    check("done_timeout", done_total != b_done, 1'b1);
    cycle();
  endtask

  function automatic logic [127:0] mk_cfg(input logic [15:0] n);
    return {32'($urandom), 32'($urandom), 32'($urandom), 16'($urandom), n};
  endfunction

  logic [127:0] cfg_a;
  int           n_rand;

  initial begin
    aresetn          = 1'b0;
    start            = 1'b0;
    cfg_parameters   = '0;
    src_i            = '0;
    src_q            = '0;
    src_valid        = 1'b0;
    wf_write_ready   = 1'b0;
    wfin_axis_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_params", waveform_parameters, 128'h0);
    check("rst_tkeep", wfin_axis_tkeep, 4'h0);
    check("rst_tvalid", wfin_axis_tvalid, 1'b0);
    check("rst_busy", busy, 1'b0);
    aresetn = 1'b1;
    cycle();

    // Basic load, N=128.
    snap();
    kick({96'h0, 32'h80});
    do_init(3);
    wait_done(600);
    check("t1_init_cycles", init_total - b_init, 4);
    check("t1_beats", beats_total - b_beats, 128);
    check("t1_tlast_count", tlast_total - b_tlast, 1);
    check("t1_tlast_pos", last_at - b_beats, 128);
    check("t1_overflow", overflow, 1'b0);
    check("t1_done_count", done_total - b_done, 1);

    // Backpressure, N=16.
    ready_pct = 50;
    snap();
    kick(mk_cfg(16'd16));
    do_init(2);
    wait_done(400);
    check("t2_beats", beats_total - b_beats, 16);
    check("t2_tlast_pos", last_at - b_beats, 16);

    // Overflow, N=64, sink stalled ~40 cycles.
    ready_pct = 0;
    snap();
    kick(mk_cfg(16'd64));
    do_init(1);
    repeat (36) cycle();
    ready_pct = 100;
    wait_done(400);
    check("t3_overflow", overflow, 1'b1);
    check("t3_beats", beats_total - b_beats, 64);
    check("t3_tlast_pos", last_at - b_beats, 64);

    // Zero length.
    snap();
    kick(mk_cfg(16'd0));
    check("t4_done_pulse", done, 1'b1);
    check("t4_ovf_cleared", overflow, 1'b0);
    cycle();
    check("t4_done_drop", done, 1'b0);
    repeat (3) cycle();
    check("t4_no_init", init_total - b_init, 0);
    check("t4_no_beats", beats_total - b_beats, 0);
    check("t4_busy", busy, 1'b0);

    // start while busy is ignored.
    ready_pct = 30;
    snap();
    cfg_a = mk_cfg(16'd8);
    kick(cfg_a);
    do_init(0);
    repeat (2) cycle();
    start          = 1'b1;
    cfg_parameters = mk_cfg(16'd5);
    cycle();
    check("t5_params_held", waveform_parameters, cfg_a);
    wait_done(300);
    check("t5_beats", beats_total - b_beats, 8);
    check("t5_tlast_pos", last_at - b_beats, 8);
    check("t5_params_end", waveform_parameters, cfg_a);

    // Reset mid-stream, then a fresh N=4 load.
    ready_pct = 100;
    snap();
    kick(mk_cfg(16'd32));
    do_init(2);
    for (int n = 0; n < 100 && (beats_total - b_beats) < 10; n++) cycle();
    check("t6_reached_10", (beats_total - b_beats) >= 10, 1'b1);
    aresetn = 1'b0;
    #1;
    check("t6_rst_tvalid", wfin_axis_tvalid, 1'b0);
    check("t6_rst_tlast", wfin_axis_tlast, 1'b0);
    check("t6_rst_tkeep", wfin_axis_tkeep, 4'h0);
    check("t6_rst_tdata", wfin_axis_tdata, 32'h0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_params", waveform_parameters, 128'h0);
    repeat (2) cycle();
    aresetn = 1'b1;
    cycle();
    snap();
    kick(mk_cfg(16'd4));
    do_init(1);
    wait_done(200);
    check("t6_beats", beats_total - b_beats, 4);
    check("t6_tlast_pos", last_at - b_beats, 4);
    check("t6_tlast_count", tlast_total - b_tlast, 1);

    // A few fully random loads.
    for (int k = 0; k < 3; k++) begin
      valid_pct = 70;
      ready_pct = 60;
      n_rand    = $urandom_range(40, 1);
      snap();
      kick(mk_cfg(16'(n_rand)));
      do_init($urandom_range(3));
      wait_done(600);
      check("rnd_beats", beats_total - b_beats, n_rand);
      check("rnd_tlast_pos", last_at - b_beats, n_rand);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
